// File: rtl/hyperspace_pkg.sv
// Shared HyperSpace constants and helpers used by the pad-side stream adapters.
package hyperspace_pkg;
  localparam int HS_IN_W      = 8;
  localparam int HS_FRAME_LEN = 2048;
  localparam int HS_OUT_W     = 16;
  localparam int HS_OUT_LEN   = 512;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction
endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with registered pointers and an occupancy count.
module stream_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             RSTB,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             full;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clock) begin
    if (RSTB) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Push on a full FIFO is only legal when the head leaves on the same edge.
  a_no_pop_empty: assert property (@(posedge clock) disable iff (RSTB) !(pop_i && empty_o));
  a_no_push_full: assert property (@(posedge clock) disable iff (RSTB) !(push_i && full && !pop_i));
endmodule

// File: rtl/gpio_in_stream_adapter.sv
// Pad ingress: registers mprj_io samples, buffers them, and regenerates frame
// boundaries from a pop counter, flagging any disagreement with pad_last.
module gpio_in_stream_adapter
  import hyperspace_pkg::*;
#(
  parameter int DATA_W      = HS_IN_W,
  parameter int FRAME_LEN   = HS_FRAME_LEN,
  parameter int FIFO_DEPTH  = 4,
  parameter int BIT_REVERSE = 1
) (
  input  logic              clock,
  input  logic              RSTB,
  input  logic [DATA_W-1:0] pad_data,
  input  logic              pad_valid,
  input  logic              pad_last,
  output logic              pad_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              frame_len_err,
  output logic [15:0]       frame_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 2;
  localparam int IW = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
  localparam logic [OW-1:0] READY_MAX = OW'(FIFO_DEPTH - 2);

  logic              stg_vld_q, stg_vld_d, stg_last_q;
  logic [DATA_W-1:0] stg_data_q;
  logic              pad_ready_q, pad_ready_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              err_q, err_d;
  logic              push, pop, empty;
  logic [AW:0]       count;
  logic [DATA_W:0]   head;
  logic [DATA_W-1:0] head_ord;
  logic [OW-1:0]     occ_d;

  assign push = stg_vld_q;
  assign pop  = m_valid && m_ready;

  stream_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .RSTB    (RSTB),
    .push_i  (push),
    .wdata_i ({stg_last_q, stg_data_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (empty),
    .count_o (count)
  );

  for (genvar i = 0; i < DATA_W; i++) begin : g_ord
    assign head_ord[i] = (BIT_REVERSE != 0) ? head[DATA_W-1-i] : head[i];
  end

  assign m_valid       = !empty;
  assign m_data        = empty ? '0 : head_ord;
  assign m_last        = m_valid && (idx_q == LAST_IDX);
  assign pad_ready     = pad_ready_q;
  assign frame_len_err = err_q;
  assign frame_cnt     = fcnt_q;

  always_comb begin
    stg_vld_d   = pad_valid && pad_ready_q;
    // Occupancy after this edge; leaving one slot spare covers the sample
    // accepted in the cycle before the lowered ready reaches the pads.
    occ_d       = OW'(count) + OW'(push) - OW'(pop) + OW'(stg_vld_d);
    pad_ready_d = (occ_d <= READY_MAX);
    idx_d  = idx_q;
    fcnt_d = fcnt_q;
    err_d  = err_q;
    if (pop) begin
      if (head[DATA_W] != m_last) err_d = 1'b1;
      if (m_last) begin
        idx_d  = '0;
        fcnt_d = fcnt_q + 16'd1;
      end else begin
        idx_d  = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (RSTB) begin
      stg_vld_q   <= 1'b0;
      stg_last_q  <= 1'b0;
      stg_data_q  <= '0;
      pad_ready_q <= 1'b0;
      idx_q       <= '0;
      fcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      stg_vld_q   <= stg_vld_d;
      stg_last_q  <= pad_last;
      stg_data_q  <= pad_data;
      pad_ready_q <= pad_ready_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      err_q       <= err_d;
    end
  end
endmodule
